// File: rtl/multi_cycle_ctrl.sv
// Control FSM for a multi-cycle MIPS datapath (addu, subu, ori, lui, lw, sw, beq, j).
// One instruction is sequenced at a time.
// All outputs are decoded from the current state, and from op/funct/zero where needed.
// A retired-instruction counter is kept for CPI measurement.
module multi_cycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    StIf     = 4'd0,
    StId     = 4'd1,
    StExeR   = 4'd2,
    StExeI   = 4'd3,
    StMemAdr = 4'd4,
    StMemRd  = 4'd5,
    StMemWr  = 4'd6,
    StWbR    = 4'd7,
    StWbI    = 4'd8,
    StWbMem  = 4'd9,
    StBeq    = 4'd10,
    StJ      = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluOr  = 3'b010;
  localparam logic [2:0] AluLui = 3'b011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  // State register; async reset returns to instruction fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIf;
    else        state_q <= state_d;
  end

  // Retired counter: count every return to IF from any other state, illegal included.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (state_q != StIf && state_d == StIf) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state and per-state datapath control decode.
  always_comb begin
    state_d    = StIf;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 1'b0;
    alu_op     = AluAdd;
    illegal    = 1'b0;
    case (state_q)
      StIf: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = StId;
      end
      StId: begin
        // Speculatively compute the branch target into alu_out.
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        if (op == OpRtype && (funct == FnAddu || funct == FnSubu)) state_d = StExeR;
        else if (op == OpOri || op == OpLui)                       state_d = StExeI;
        else if (op == OpLw || op == OpSw)                         state_d = StMemAdr;
        else if (op == OpBeq)                                      state_d = StBeq;
        else if (op == OpJ)                                        state_d = StJ;
        else begin
          illegal = 1'b1;
          state_d = StIf;
        end
      end
      StExeR: begin
        alu_src_a = 1'b1;
        alu_op    = (funct == FnSubu) ? AluSub : AluAdd;
        state_d   = StWbR;
      end
      StExeI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op == OpLui) ? AluLui : AluOr;
        state_d   = StWbI;
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        state_d   = (op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        state_d  = StWbMem;
      end
      StMemWr: begin
        mem_write = 1'b1;
        state_d   = StIf;
      end
      StWbR: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StIf;
      end
      StWbI: begin
        reg_write = 1'b1;
        state_d   = StIf;
      end
      StWbMem: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StIf;
      end
      StBeq: begin
        alu_src_a = 1'b1;
        alu_op    = AluSub;
        pc_src    = 2'b01;
        pc_write  = zero;
        state_d   = StIf;
      end
      StJ: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = StIf;
      end
      default: state_d = StIf;
    endcase
    // Hold every enable off while reset is asserted; selects keep their IF values.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class through its states.
module tb_multi_cycle_ctrl;

  logic        clock, reset;
  logic [5:0]  op, funct;
  logic        zero;
  logic        pc_write, ir_write, reg_write, reg_dst, mem_to_reg, mem_read, mem_write;
  logic        alu_src_a, ext_op, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  int vectors = 0;
  int miscompares = 0;

  multi_cycle_ctrl #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .illegal(illegal), .state(state), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and settle.
  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", retired, 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_alu_src_b", 32'(alu_src_b), 1);

    // addu
    reset = 1'b1; op = 6'h00; funct = 6'h21;
    #1;
    chk("addu_if_ir_write", 32'(ir_write), 1);
    chk("addu_if_pc_write", 32'(pc_write), 1);
    chk("addu_if_pc_src", 32'(pc_src), 0);
    cyc(); chk("addu_id", 32'(state), 1);
    chk("addu_id_alu_src_b", 32'(alu_src_b), 3);
    chk("addu_id_ext_op", 32'(ext_op), 1);
    chk("addu_id_pc_write", 32'(pc_write), 0);
    cyc(); chk("addu_exe", 32'(state), 2);
    chk("addu_exe_src_a", 32'(alu_src_a), 1);
    chk("addu_exe_alu_op", 32'(alu_op), 0);
    chk("addu_exe_reg_write", 32'(reg_write), 0);
    cyc(); chk("addu_wb", 32'(state), 7);
    chk("addu_wb_reg_write", 32'(reg_write), 1);
    chk("addu_wb_reg_dst", 32'(reg_dst), 1);
    cyc(); chk("addu_done", 32'(state), 0);
    chk("addu_retired", retired, 1);

    // subu
    funct = 6'h23;
    cyc(); chk("subu_id", 32'(state), 1);
    cyc(); chk("subu_exe", 32'(state), 2);
    chk("subu_alu_op", 32'(alu_op), 1);
    cyc(); chk("subu_wb", 32'(state), 7);
    cyc(); chk("subu_retired", retired, 2);

    // lw
    op = 6'h23;
    cyc(); chk("lw_id", 32'(state), 1);
    cyc(); chk("lw_adr", 32'(state), 4);
    chk("lw_adr_src_b", 32'(alu_src_b), 2);
    chk("lw_adr_ext_op", 32'(ext_op), 1);
    cyc(); chk("lw_rd", 32'(state), 5);
    chk("lw_mem_read", 32'(mem_read), 1);
    chk("lw_rd_reg_write", 32'(reg_write), 0);
    cyc(); chk("lw_wb", 32'(state), 9);
    chk("lw_wb_reg_write", 32'(reg_write), 1);
    chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 1);
    chk("lw_wb_reg_dst", 32'(reg_dst), 0);
    cyc(); chk("lw_done", 32'(state), 0);
    chk("lw_retired", retired, 3);

    // sw
    op = 6'h2b;
    cyc(); chk("sw_id", 32'(state), 1);
    cyc(); chk("sw_adr", 32'(state), 4);
    cyc(); chk("sw_wr", 32'(state), 6);
    chk("sw_mem_write", 32'(mem_write), 1);
    chk("sw_reg_write", 32'(reg_write), 0);
    cyc(); chk("sw_done", 32'(state), 0);
    chk("sw_retired", retired, 4);

    // beq taken
    op = 6'h04; zero = 1'b1;
    cyc(); chk("beq1_id", 32'(state), 1);
    cyc(); chk("beq1_state", 32'(state), 10);
    chk("beq1_pc_write", 32'(pc_write), 1);
    chk("beq1_pc_src", 32'(pc_src), 1);
    chk("beq1_alu_op", 32'(alu_op), 1);
    cyc(); chk("beq1_done", 32'(state), 0);
    chk("beq1_retired", retired, 5);

    // beq not taken
    zero = 1'b0;
    cyc(); chk("beq0_id", 32'(state), 1);
    cyc(); chk("beq0_state", 32'(state), 10);
    chk("beq0_pc_write", 32'(pc_write), 0);
    cyc(); chk("beq0_done", 32'(state), 0);
    chk("beq0_retired", retired, 6);

    // lui
    op = 6'h0f;
    cyc(); chk("lui_id", 32'(state), 1);
    cyc(); chk("lui_exe", 32'(state), 3);
    chk("lui_alu_op", 32'(alu_op), 3);
    chk("lui_src_b", 32'(alu_src_b), 2);
    chk("lui_ext_op", 32'(ext_op), 0);
    cyc(); chk("lui_wb", 32'(state), 8);
    chk("lui_wb_reg_write", 32'(reg_write), 1);
    chk("lui_wb_reg_dst", 32'(reg_dst), 0);
    cyc(); chk("lui_retired", retired, 7);

    // ori
    op = 6'h0d;
    cyc(); chk("ori_id", 32'(state), 1);
    cyc(); chk("ori_exe", 32'(state), 3);
    chk("ori_alu_op", 32'(alu_op), 2);
    cyc(); chk("ori_wb", 32'(state), 8);
    cyc(); chk("ori_retired", retired, 8);

    // j
    op = 6'h02;
    cyc(); chk("j_id", 32'(state), 1);
    cyc(); chk("j_state", 32'(state), 11);
    chk("j_pc_write", 32'(pc_write), 1);
    chk("j_pc_src", 32'(pc_src), 2);
    cyc(); chk("j_done", 32'(state), 0);
    chk("j_retired", retired, 9);

    // illegal opcode, then R-type with unsupported funct
    op = 6'h3f;
    cyc(); chk("ill1_id", 32'(state), 1);
    chk("ill1_pulse", 32'(illegal), 1);
    chk("ill1_reg_write", 32'(reg_write), 0);
    chk("ill1_mem_write", 32'(mem_write), 0);
    cyc(); chk("ill1_done", 32'(state), 0);
    chk("ill1_pulse_end", 32'(illegal), 0);
    chk("ill1_retired", retired, 10);
    op = 6'h00; funct = 6'h00;
    cyc(); chk("ill2_id", 32'(state), 1);
    chk("ill2_pulse", 32'(illegal), 1);
    cyc(); chk("ill2_done", 32'(state), 0);
    chk("ill2_pulse_end", 32'(illegal), 0);
    chk("ill2_retired", retired, 11);

    // reset asserted during MEM_WR
    op = 6'h2b;
    cyc(); chk("rsw_id", 32'(state), 1);
    cyc(); chk("rsw_adr", 32'(state), 4);
    cyc(); chk("rsw_wr", 32'(state), 6);
    chk("rsw_mem_write", 32'(mem_write), 1);
    reset = 1'b0;
    #1;
    chk("rsw_async_mem_write", 32'(mem_write), 0);
    chk("rsw_async_state", 32'(state), 0);
    chk("rsw_async_retired", retired, 0);
    cyc(); chk("rsw_held_state", 32'(state), 0);
    chk("rsw_held_ir_write", 32'(ir_write), 0);

    // first instruction after release
    reset = 1'b1; op = 6'h00; funct = 6'h21;
    #1;
    chk("post_if_ir_write", 32'(ir_write), 1);
    cyc(); chk("post_id", 32'(state), 1);
    cyc(); chk("post_exe", 32'(state), 2);
    cyc(); chk("post_wb", 32'(state), 7);
    chk("post_wb_reg_write", 32'(reg_write), 1);
    cyc(); chk("post_done", 32'(state), 0);
    chk("post_retired", retired, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Moore-style control FSM that sequences the multi-cycle MIPS datapath (pc, im/ir, gpr, alu, data memory) one instruction at a time.
- Decodes op/funct from the instruction register and drives every datapath enable and mux select per cycle.
- Supports addu, subu, ori, lui, lw, sw, beq and j.
- Keeps a retired-instruction counter for bench CPI checks.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  ir[31:26]; stable from ID until next IF
funct  in  6  ir[5:0]
zero  in  1  alu result == 0
pc_write  out  1  pc register load enable
pc_src  out  2  00 alu result (pc+4), 01 alu_out reg (branch target), 10 jump {pc[31:28],ir[25:0],2'b00}
ir_write  out  1  instruction register load enable
reg_write  out  1  gpr write enable
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 alu_out, 1 mem data reg
mem_read  out  1  data memory read strobe
mem_write  out  1  data memory write enable
alu_src_a  out  1  0 pc, 1 gpr a
alu_src_b  out  2  00 gpr b, 01 const 4, 10 extended imm, 11 sext(imm)<<2
ext_op  out  1  0 zero-extend, 1 sign-extend
alu_op  out  3  000 add, 001 sub, 010 or, 011 lui (b<<16)
illegal  out  1  one-cycle pulse on undecodable instruction
state  out  4  current state encoding (debug)
retired  out  CNT_W  count of completed instructions

Behaviour:
- reset low (async): state=IF, retired=0, all enables forced 0 while asserted. Selects follow IF decode.
- First rising edge after reset deasserts executes IF.
- All outputs are combinational decode of state (plus op/zero where listed). No output register latency.
- Unlisted outputs in a state are 0.
- States: IF=0, ID=1, EXE_R=2, EXE_I=3, MEM_ADR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BEQ=10, J=11. Codes 12-15 are unreachable and go to IF.
- IF: ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=add. Next state ID.
- ID: alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=add (precomputes branch target into alu_out). Next state by decode:
  - op=000000 & funct=100001/100011 -> EXE_R
  - op=001101/001111 -> EXE_I
  - op=100011/101011 -> MEM_ADR
  - op=000100 -> BEQ
  - op=000010 -> J
  - otherwise illegal=1 for this cycle, next IF (instruction treated as nop).
- EXE_R: alu_src_a=1, alu_src_b=00, alu_op=add (addu) or sub (subu). Next WB_R.
- EXE_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_op=or (ori) or lui (lui). Next WB_I.
- MEM_ADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=add. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1. Next WB_MEM.
- MEM_WR: mem_write=1. Next IF.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Next IF.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Next IF.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Next IF.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01, pc_write=zero. Next IF.
- J: pc_write=1, pc_src=10. Next IF.
- Cycles per instruction (IF through last state):
  - R-type 4, ori/lui 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- retired increments by 1 on every transition from a non-IF state into IF, including illegal. Wraps modulo 2^CNT_W.
- reg_write and mem_write are never both 1. pc_write is 1 only in IF, J, or BEQ with zero=1.
- Reset asserted mid-instruction: immediate return to IF with all enables 0. No partial write completes after reset falls.

Test Plan:
- Reset low for 3 cycles, release, op=000000 funct=100001: state sequence 0,1,2,7,0. reg_write=1 with reg_dst=1 only in cycle 4. retired=1.
- lw (op=100011): states 0,1,4,5,9,0. mem_read=1 in cycle 4, reg_write+mem_to_reg=1 in cycle 5. sw (101011): mem_write=1 in cycle 4, never reg_write.
- beq with zero=1: pc_write=1, pc_src=01 in cycle 3. Repeat with zero=0: pc_write=0 in cycle 3. Both take 3 cycles.
- lui (001111): alu_op=011, alu_src_b=10, ext_op=0 in EXE_I. ori gives alu_op=010. j gives pc_src=10 in cycle 3.
- Illegal op=111111, then op=000000 funct=000000: illegal pulses exactly 1 cycle in each ID, next state IF, no reg/mem write. retired increments twice.
- Drive reset low during MEM_WR: mem_write drops to 0 asynchronously, state=IF, retired=0. After release, first instruction runs normally.
